wb_gpio_n: RTL and testbench

Parametrised Wishbone GPIO target, the next generation of the fixed 8-bit payload GPIO. It attaches to one target port of the system interconnect. Adds over the fixed GPIO:
- N-bit width and per-bit output enable
- atomic set/clear/toggle writes and byte-lane selects
- input synchronisers
- rising/falling edge detection with a sticky, W1C interrupt status and a level irq output

---
 rtl/wb_gpio_n.sv | 145 ++++++++++++++
 tb/tb_wb_gpio_n.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/wb_gpio_n.sv
// Purpose : parametrised Wishbone GPIO target with per-bit output enable, atomic SET/CLR/TGL,
//           input synchronisers and sticky W1C rise/fall edge interrupt status.
// Latency : ack_o and dat_r_o one cycle after the request edge; write effects land on that edge.
// Backpressure: none; a request held across its ack is not re-acked, so each transfer takes >= 2 cycles.
// Ports   : clock/reset (async active-high); Wishbone target adr_i/dat_w_i/dat_r_o/cyc_i/stb_i/
//           we_i/sel_i/ack_o/err_o; pads gpio_in (async), gpio_out, gpio_oeb (active-low OE); irq level.
module wb_gpio_n #(
    parameter int N_GPIO      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       adr_i,
    input  logic [31:0]       dat_w_i,
    output logic [31:0]       dat_r_o,
    input  logic              cyc_i,
    input  logic              stb_i,
    input  logic              we_i,
    input  logic [3:0]        sel_i,
    output logic              ack_o,
    output logic              err_o,
    input  logic [N_GPIO-1:0] gpio_in,
    output logic [N_GPIO-1:0] gpio_out,
    output logic [N_GPIO-1:0] gpio_oeb,
    output logic              irq
);

    localparam logic [3:0] A_OUT    = 4'h0;
    localparam logic [3:0] A_IN     = 4'h1;
    localparam logic [3:0] A_OE     = 4'h2;
    localparam logic [3:0] A_SET    = 4'h3;
    localparam logic [3:0] A_CLR    = 4'h4;
    localparam logic [3:0] A_TGL    = 4'h5;
    localparam logic [3:0] A_RISE   = 4'h6;
    localparam logic [3:0] A_FALL   = 4'h7;
    localparam logic [3:0] A_STATUS = 4'h8;

    localparam int               ARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_INIT = ARM_W'(SYNC_STAGES + 1);

    logic [N_GPIO-1:0] out_q, oe_q, rise_en_q, fall_en_q, status_q, prev_q;
    logic [N_GPIO-1:0] out_d, oe_d, rise_en_d, fall_en_d, status_d;
    logic [SYNC_STAGES-1:0][N_GPIO-1:0] sync_chain;
    logic [N_GPIO-1:0] sync_val;
    logic [ARM_W-1:0]  arm_q;

    logic              req, wr;
    logic [3:0]        word;
    logic [31:0]       mask32, wdat32, rd32;
    logic [N_GPIO-1:0] m, d, rd_n, rise, fall, w1c;

    // Address bits outside the word offset and data bits above N_GPIO are don't-care.
    logic unused_bits;
    assign unused_bits = ^{adr_i[31:6], adr_i[1:0], wdat32};

    assign sync_val = sync_chain[SYNC_STAGES-1];
    assign gpio_out = out_q;
    assign gpio_oeb = ~oe_q;
    assign irq      = |status_q;
    assign err_o    = 1'b0;

    always_comb begin
        // ~ack_o keeps a held strobe from being taken twice.
        req    = cyc_i & stb_i & ~ack_o;
        wr     = req & we_i;
        word   = adr_i[5:2];
        mask32 = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};
        wdat32 = dat_w_i & mask32;
        m      = mask32[N_GPIO-1:0];
        d      = wdat32[N_GPIO-1:0];

        // Edges are ignored until the sync chain and prev have flushed their reset zeros.
        rise = '0;
        fall = '0;
        if (arm_q == '0) begin
            rise = sync_val & ~prev_q & rise_en_q;
            fall = ~sync_val & prev_q & fall_en_q;
        end

        out_d     = out_q;
        oe_d      = oe_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c       = '0;
        if (wr) begin
            case (word)
                A_OUT:    out_d     = (out_q & ~m) | d;
                A_OE:     oe_d      = (oe_q & ~m) | d;
                A_SET:    out_d     = out_q | d;
                A_CLR:    out_d     = out_q & ~d;
                A_TGL:    out_d     = out_q ^ d;
                A_RISE:   rise_en_d = (rise_en_q & ~m) | d;
                A_FALL:   fall_en_d = (fall_en_q & ~m) | d;
                A_STATUS: w1c       = d;
                default:  ;
            endcase
        end
        // New edges are OR-ed in after the clear, so a same-cycle edge keeps its bit set.
        status_d = (status_q & ~w1c) | rise | fall;

        rd_n = '0;
        case (word)
            A_OUT:    rd_n = out_q;
            A_IN:     rd_n = sync_val;
            A_OE:     rd_n = oe_q;
            A_RISE:   rd_n = rise_en_q;
            A_FALL:   rd_n = fall_en_q;
            A_STATUS: rd_n = status_q;
            default:  rd_n = '0;
        endcase
        rd32 = '0;
        rd32[N_GPIO-1:0] = rd_n;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_q      <= '0;
            oe_q       <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            status_q   <= '0;
            prev_q     <= '0;
            sync_chain <= '0;
            arm_q      <= ARM_INIT;
            ack_o      <= 1'b0;
            dat_r_o    <= '0;
        end else begin
            out_q      <= out_d;
            oe_q       <= oe_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            status_q   <= status_d;
            prev_q     <= sync_val;
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], gpio_in};
            if (arm_q != '0) begin
                arm_q <= arm_q - 1'b1;
            end
            ack_o <= req;
            if (req) begin
                dat_r_o <= rd32;
            end
        end
    end

endmodule

// File: tb/tb_wb_gpio_n.sv
// Purpose : directed bench for wb_gpio_n; an 8-bit and a 12-bit instance share one Wishbone bus.
// Latency : transfers are driven #1 after an edge and sampled #1 after the following edge.
// Backpressure: ack is expected exactly one cycle after the request edge.
module tb_wb_gpio_n;

    localparam int SS = 2;

    logic        clock, reset;
    logic [31:0] adr, dat_w;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [7:0]  gpio_in;

    logic [31:0] dat_r8, dat_r12;
    logic        ack8, ack12, err8, err12, irq8, irq12;
    logic [7:0]  gpio_out8, gpio_oeb8;
    logic [11:0] gpio_out12, gpio_oeb12;

    int checks = 0;
    int failures = 0;
    logic [31:0] r8, r12, hold;

    wb_gpio_n #(.N_GPIO(8), .SYNC_STAGES(SS)) dut8 (
        .clock(clock), .reset(reset), .adr_i(adr), .dat_w_i(dat_w), .dat_r_o(dat_r8),
        .cyc_i(cyc), .stb_i(stb), .we_i(we), .sel_i(sel), .ack_o(ack8), .err_o(err8),
        .gpio_in(gpio_in), .gpio_out(gpio_out8), .gpio_oeb(gpio_oeb8), .irq(irq8));

    wb_gpio_n #(.N_GPIO(12), .SYNC_STAGES(SS)) dut12 (
        .clock(clock), .reset(reset), .adr_i(adr), .dat_w_i(dat_w), .dat_r_o(dat_r12),
        .cyc_i(cyc), .stb_i(stb), .we_i(we), .sel_i(sel), .ack_o(ack12), .err_o(err12),
        .gpio_in({4'h0, gpio_in}), .gpio_out(gpio_out12), .gpio_oeb(gpio_oeb12), .irq(irq12));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One transfer on the shared bus; both instances must ack on the cycle after the request edge.
    task automatic wb(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd8, output logic [31:0] rd12);
        @(posedge clock); #1;
        adr = a; we = w; dat_w = d; sel = s; cyc = 1'b1; stb = 1'b1;
        @(posedge clock); #1;
        chk("ack8", {31'b0, ack8}, 32'd1);
        chk("ack12", {31'b0, ack12}, 32'd1);
        rd8 = dat_r8;
        rd12 = dat_r12;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; adr = '0; dat_w = '0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0;
        gpio_in = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_out", {24'b0, gpio_out8}, 32'h0);
        chk("rst_oeb", {24'b0, gpio_oeb8}, 32'hFF);
        chk("rst_irq", {31'b0, irq8}, 32'h0);
        chk("rst_ack", {31'b0, ack8}, 32'h0);
        chk("rst_datr", dat_r8, 32'h0);
        chk("err", {30'b0, err8, err12}, 32'h0);
        reset = 1'b0;

        wb(32'h00, 1'b0, 0, 4'hF, r8, r12); chk("rd_out0", r8, 32'h0);
        wb(32'h08, 1'b0, 0, 4'hF, r8, r12); chk("rd_oe0", r8, 32'h0);
        wb(32'h20, 1'b0, 0, 4'hF, r8, r12); chk("rd_stat0", r8, 32'h0);
        @(posedge clock); #1;
        chk("ack_one_cycle", {31'b0, ack8}, 32'h0);

        // Output data path and atomic updates.
        wb(32'h00, 1'b1, 32'h0000_00A5, 4'b0001, r8, r12); chk("out_a5", {24'b0, gpio_out8}, 32'hA5);
        wb(32'h0C, 1'b1, 32'h0000_000F, 4'b0001, r8, r12); chk("set_0f", {24'b0, gpio_out8}, 32'hAF);
        wb(32'h10, 1'b1, 32'h0000_0081, 4'b0001, r8, r12); chk("clr_81", {24'b0, gpio_out8}, 32'h2E);
        wb(32'h14, 1'b1, 32'h0000_00FF, 4'b0001, r8, r12); chk("tgl_ff", {24'b0, gpio_out8}, 32'hD1);
        wb(32'h0C, 1'b1, 32'h0000_FF00, 4'b0001, r8, r12); chk("set_lane", {24'b0, gpio_out8}, 32'hD1);
        wb(32'h0C, 1'b1, 32'h0000_0022, 4'b0000, r8, r12); chk("set_nosel", {24'b0, gpio_out8}, 32'hD1);
        wb(32'h0C, 1'b0, 0, 4'hF, r8, r12); chk("rd_set_wo", r8, 32'h0);
        wb(32'h00, 1'b0, 0, 4'hF, r8, r12); chk("rd_out_d1", r8, 32'hD1);
        hold = r8;
        repeat (2) @(posedge clock);
        #1;
        chk("datr_hold", dat_r8, hold);
        wb(32'h08, 1'b1, 32'h0000_003C, 4'b0001, r8, r12); chk("oeb_c3", {24'b0, gpio_oeb8}, 32'hC3);

        // Edge detection and W1C.
        gpio_in = 8'h02;
        repeat (6) @(posedge clock);
        wb(32'h18, 1'b1, 32'h01, 4'hF, r8, r12);
        wb(32'h1C, 1'b1, 32'h02, 4'hF, r8, r12);
        wb(32'h20, 1'b0, 0, 4'hF, r8, r12); chk("stat_idle", r8, 32'h0);
        @(posedge clock); #1;
        gpio_in = 8'h01;
        repeat (SS) @(posedge clock);
        #1;
        chk("irq_early", {31'b0, irq8}, 32'h0);
        @(posedge clock); #1;
        chk("irq_on_time", {31'b0, irq8}, 32'h1);
        wb(32'h20, 1'b0, 0, 4'hF, r8, r12); chk("stat_03", r8, 32'h03);
        wb(32'h20, 1'b1, 32'h01, 4'hF, r8, r12);
        wb(32'h20, 1'b0, 0, 4'hF, r8, r12); chk("stat_02", r8, 32'h02);
        chk("irq_still", {31'b0, irq8}, 32'h1);
        wb(32'h20, 1'b1, 32'h02, 4'hF, r8, r12);
        chk("irq_clear", {31'b0, irq8}, 32'h0);

        // W1C landing on the same edge as a new rising edge: the edge wins.
        gpio_in = 8'h00;
        repeat (6) @(posedge clock);
        #1;
        gpio_in = 8'h01;
        repeat (SS - 1) @(posedge clock);
        wb(32'h20, 1'b1, 32'h01, 4'hF, r8, r12);
        wb(32'h20, 1'b0, 0, 4'hF, r8, r12); chk("set_wins", r8, 32'h01);
        wb(32'h20, 1'b1, 32'h01, 4'hF, r8, r12);
        wb(32'h20, 1'b0, 0, 4'hF, r8, r12); chk("w1c_after", r8, 32'h00);

        // High pins through reset with rise enables set right away: no spurious edge.
        gpio_in = 8'hFF;
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        chk("async_rst_out", {24'b0, gpio_out8}, 32'h0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        wb(32'h18, 1'b1, 32'hFF, 4'hF, r8, r12);
        repeat (8) @(posedge clock);
        wb(32'h20, 1'b0, 0, 4'hF, r8, r12); chk("arm_stat8", r8, 32'h0); chk("arm_stat12", r12, 32'h0);
        chk("arm_irq", {31'b0, irq8}, 32'h0);
        wb(32'h04, 1'b0, 0, 4'hF, r8, r12); chk("in8", r8, 32'hFF); chk("in12", r12, 32'h0FF);

        // Width limits, unmapped space and held strobe on the 12-bit instance.
        wb(32'h00, 1'b1, 32'hFFFF_FFFF, 4'hF, r8, r12);
        wb(32'h00, 1'b0, 0, 4'hF, r8, r12); chk("out12_rd", r12, 32'h0000_0FFF);
        chk("out12_pins", {20'b0, gpio_out12}, 32'hFFF);
        wb(32'h30, 1'b1, 32'hFFFF_FFFF, 4'hF, r8, r12);
        wb(32'h30, 1'b0, 0, 4'hF, r8, r12); chk("unmapped_rd", r12, 32'h0);
        wb(32'h00, 1'b0, 0, 4'hF, r8, r12); chk("unmapped_nochg", r12, 32'h0000_0FFF);
        chk("unmapped_oeb", {20'b0, gpio_oeb12}, 32'hFFF);
        wb(32'h00, 1'b1, 32'h0000_0000, 4'b0010, r8, r12);
        wb(32'h00, 1'b0, 0, 4'hF, r8, r12); chk("lane1_clr", r12, 32'h0000_00FF);

        @(posedge clock); #1;
        adr = 32'h00; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clock); #1;
        chk("hold_ack1", {31'b0, ack12}, 32'h1);
        @(posedge clock); #1;
        chk("hold_ack2", {31'b0, ack12}, 32'h0);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clock); #1;
        chk("hold_ack3", {31'b0, ack12}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
